// File: rtl/nbody_force_engine.sv
// Direct-sum N-body force engine: sweeps every ordered body pair from body RAM,
// accumulates m_i*m_j*(r_j - r_i) per body and writes saturated {fx, fy} words.
module nbody_force_engine #(
  parameter int N_BODIES   = 2,
  parameter int W          = 16,
  parameter int ADDR_W     = 9,
  parameter int FORCE_BASE = 400,
  parameter int G_SHIFT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] body_addr,
  output logic              body_rd_en,
  input  logic [5*W-1:0]    body_rdata,
  output logic [ADDR_W-1:0] force_addr,
  output logic              force_wr_en,
  output logic [2*W-1:0]    force_wdata
);
  localparam int ACC_W  = 3*W + 2 + $clog2(N_BODIES);
  localparam int PROD_W = 3*W + 2;
  localparam int CNT_W  = $clog2(N_BODIES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BODIES);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH_I = 3'd1;
  localparam logic [2:0] S_LATCH_I = 3'd2;
  localparam logic [2:0] S_FETCH_J = 3'd3;
  localparam logic [2:0] S_LATCH_J = 3'd4;
  localparam logic [2:0] S_MAC     = 3'd5;
  localparam logic [2:0] S_WRITE   = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]              state_q, state_d;
  logic [CNT_W-1:0]        i_q, i_d, j_q, j_d;
  logic [W-1:0]            xi_q, xi_d, yi_q, yi_d, mi_q, mi_d;
  logic [W-1:0]            xj_q, xj_d, yj_q, yj_d, mj_q, mj_d;
  logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    body_rd_en_q, body_rd_en_d, force_wr_en_q, force_wr_en_d;
  logic [ADDR_W-1:0]       body_addr_q, body_addr_d, force_addr_q, force_addr_d;
  logic [2*W-1:0]          force_wdata_q, force_wdata_d;

  logic [W-1:0]             rd_x, rd_y, rd_m;
  logic signed [W:0]        dx, dy;
  logic [2*W-1:0]           mm;
  logic signed [PROD_W-1:0] prod_x, prod_y;

  // Velocity fields ride along in the body word but play no part in the force.
  logic unused_vel;
  assign unused_vel = ^body_rdata[3*W-1:W];

  assign rd_x = body_rdata[5*W-1:4*W];
  assign rd_y = body_rdata[4*W-1:3*W];
  assign rd_m = body_rdata[W-1:0];

  function automatic logic [W-1:0] sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> G_SHIFT;
    if (sh > SAT_MAX) return SAT_MAX[W-1:0];
    if (sh < SAT_MIN) return SAT_MIN[W-1:0];
    return sh[W-1:0];
  endfunction

  always_comb begin
    // NOTE: every _d defaults to its held value first, so no path through the
    // case statement can leave a signal unassigned and infer a latch.
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    xi_d    = xi_q;
    yi_d    = yi_q;
    mi_d    = mi_q;
    xj_d    = xj_q;
    yj_d    = yj_q;
    mj_d    = mj_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;

    // Sign-extend to W+1 bits so the difference of two extreme coordinates fits.
    dx     = {xj_q[W-1], xj_q} - {xi_q[W-1], xi_q};
    dy     = {yj_q[W-1], yj_q} - {yi_q[W-1], yi_q};
    mm     = {{W{1'b0}}, mi_q} * {{W{1'b0}}, mj_q};
    prod_x = $signed({{(W+2){1'b0}}, mm}) * $signed({{(2*W+1){dx[W]}}, dx});
    prod_y = $signed({{(W+2){1'b0}}, mm}) * $signed({{(2*W+1){dy[W]}}, dy});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH_I;
          i_d     = '0;
        end
      end
      S_FETCH_I: state_d = S_LATCH_I;
      S_LATCH_I: begin
        xi_d    = rd_x;
        yi_d    = rd_y;
        mi_d    = rd_m;
        acc_x_d = '0;
        acc_y_d = '0;
        j_d     = '0;
        state_d = S_FETCH_J;
      end
      S_FETCH_J: begin
        if (j_q == i_q) begin
          j_d     = j_q + CNT_W'(1);
          state_d = (j_d == LAST) ? S_WRITE : S_FETCH_J;
        end else begin
          state_d = S_LATCH_J;
        end
      end
      S_LATCH_J: begin
        xj_d    = rd_x;
        yj_d    = rd_y;
        mj_d    = rd_m;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_x_d = acc_x_q + ACC_W'(prod_x);
        acc_y_d = acc_y_q + ACC_W'(prod_y);
        j_d     = j_q + CNT_W'(1);
        state_d = (j_d == LAST) ? S_WRITE : S_FETCH_J;
      end
      S_WRITE: begin
        i_d     = i_q + CNT_W'(1);
        state_d = (i_d == LAST) ? S_DONE : S_FETCH_I;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    body_rd_en_d  = (state_d == S_FETCH_I) || ((state_d == S_FETCH_J) && (j_d != i_d));
    body_addr_d   = body_addr_q;
    force_wr_en_d = (state_d == S_WRITE);
    force_addr_d  = force_addr_q;
    force_wdata_d = force_wdata_q;
    if (state_d == S_FETCH_I) begin
      body_addr_d = ADDR_W'(i_d);
    end else if (body_rd_en_d) begin
      body_addr_d = ADDR_W'(j_d);
    end
    if (force_wr_en_d) begin
      force_addr_d  = ADDR_W'(FORCE_BASE) + ADDR_W'(i_d);
      force_wdata_d = {sat(acc_x_d), sat(acc_y_d)};
    end
  end

  // NOTE: sequential state is written only with <= so every flop samples the
  // pre-edge values; reset is synchronous and clears the whole datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      i_q           <= '0;
      j_q           <= '0;
      xi_q          <= '0;
      yi_q          <= '0;
      mi_q          <= '0;
      xj_q          <= '0;
      yj_q          <= '0;
      mj_q          <= '0;
      acc_x_q       <= '0;
      acc_y_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      body_rd_en_q  <= 1'b0;
      body_addr_q   <= '0;
      force_wr_en_q <= 1'b0;
      force_addr_q  <= '0;
      force_wdata_q <= '0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      xi_q          <= xi_d;
      yi_q          <= yi_d;
      mi_q          <= mi_d;
      xj_q          <= xj_d;
      yj_q          <= yj_d;
      mj_q          <= mj_d;
      acc_x_q       <= acc_x_d;
      acc_y_q       <= acc_y_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      body_rd_en_q  <= body_rd_en_d;
      body_addr_q   <= body_addr_d;
      force_wr_en_q <= force_wr_en_d;
      force_addr_q  <= force_addr_d;
      force_wdata_q <= force_wdata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign body_rd_en  = body_rd_en_q;
  assign body_addr   = body_addr_q;
  assign force_wr_en = force_wr_en_q;
  assign force_addr  = force_addr_q;
  assign force_wdata = force_wdata_q;

endmodule

// File: tb/tb_nbody_force_engine.sv
// Bench for nbody_force_engine: three instances (N=2, N=4/G_SHIFT=4, N=1) fed from
// small body RAMs and checked against a direct-sum reference model and fixed vectors.
module tb_nbody_force_engine;
  typedef logic [79:0] body_arr_t [4];
  typedef logic [31:0] fvec_t [4];
  typedef struct {
    logic [15:0] x0, y0, m0, x1, y1, m1;
    logic [31:0] f0, f1;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic        rd_a, rd_b, rd_c, wr_a, wr_b, wr_c;
  logic [8:0]  addr_a, addr_b, addr_c, faddr_a, faddr_b, faddr_c;
  logic [79:0] rdata_a = '0, rdata_b = '0, rdata_c = '0;
  logic [31:0] wdata_a, wdata_b, wdata_c;

  nbody_force_engine #(.N_BODIES(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .body_addr(addr_a), .body_rd_en(rd_a), .body_rdata(rdata_a),
    .force_addr(faddr_a), .force_wr_en(wr_a), .force_wdata(wdata_a));
  nbody_force_engine #(.N_BODIES(4), .G_SHIFT(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .body_addr(addr_b), .body_rd_en(rd_b), .body_rdata(rdata_b),
    .force_addr(faddr_b), .force_wr_en(wr_b), .force_wdata(wdata_b));
  nbody_force_engine #(.N_BODIES(1)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .busy(busy_c), .done(done_c),
    .body_addr(addr_c), .body_rd_en(rd_c), .body_rdata(rdata_c),
    .force_addr(faddr_c), .force_wr_en(wr_c), .force_wdata(wdata_c));

  logic [79:0] mem_a [2];
  logic [79:0] mem_b [4];
  logic [79:0] mem_c [1];

  always @(posedge clk) begin
    if (rd_a) rdata_a <= (addr_a < 9'd2) ? mem_a[addr_a[0]] : '0;
    if (rd_b) rdata_b <= (addr_b < 9'd4) ? mem_b[addr_b[1:0]] : '0;
    if (rd_c) rdata_c <= (addr_c == 9'd0) ? mem_c[0] : '0;
  end

  // Event logs, appended only by the monitors and read by the test sequence.
  int rd_q_a[$], rd_q_b[$], rd_q_c[$];
  int wa_q_a[$], wa_q_b[$], wa_q_c[$];
  int wc_q_a[$], wc_q_b[$], wc_q_c[$];
  logic [31:0] wd_q_a[$], wd_q_b[$], wd_q_c[$];
  int dn_a = 0, dn_b = 0, dn_c = 0;
  int dc_a = 0, dc_b = 0, dc_c = 0;
  int ov_a = 0, ov_b = 0, ov_c = 0;

  always @(negedge clk) begin
    if (rd_a) rd_q_a.push_back(int'(addr_a));
    if (wr_a) begin wa_q_a.push_back(int'(faddr_a)); wd_q_a.push_back(wdata_a); wc_q_a.push_back(cyc); end
    if (done_a) begin dn_a++; dc_a = cyc; end
    if (rd_a && wr_a) ov_a++;
  end
  always @(negedge clk) begin
    if (rd_b) rd_q_b.push_back(int'(addr_b));
    if (wr_b) begin wa_q_b.push_back(int'(faddr_b)); wd_q_b.push_back(wdata_b); wc_q_b.push_back(cyc); end
    if (done_b) begin dn_b++; dc_b = cyc; end
    if (rd_b && wr_b) ov_b++;
  end
  always @(negedge clk) begin
    if (rd_c) rd_q_c.push_back(int'(addr_c));
    if (wr_c) begin wa_q_c.push_back(int'(faddr_c)); wd_q_c.push_back(wdata_c); wc_q_c.push_back(cyc); end
    if (done_c) begin dn_c++; dc_c = cyc; end
    if (rd_c && wr_c) ov_c++;
  end

  function automatic int n_rd(int w);
    case (w) 0: return rd_q_a.size(); 1: return rd_q_b.size(); default: return rd_q_c.size(); endcase
  endfunction
  function automatic int n_wr(int w);
    case (w) 0: return wa_q_a.size(); 1: return wa_q_b.size(); default: return wa_q_c.size(); endcase
  endfunction
  function automatic int n_done(int w);
    case (w) 0: return dn_a; 1: return dn_b; default: return dn_c; endcase
  endfunction
  function automatic int done_cyc(int w);
    case (w) 0: return dc_a; 1: return dc_b; default: return dc_c; endcase
  endfunction
  function automatic int overlaps(int w);
    case (w) 0: return ov_a; 1: return ov_b; default: return ov_c; endcase
  endfunction
  function automatic int rd_at(int w, int k);
    if (k >= n_rd(w)) return -1;
    case (w) 0: return rd_q_a[k]; 1: return rd_q_b[k]; default: return rd_q_c[k]; endcase
  endfunction
  function automatic int wa_at(int w, int k);
    if (k >= n_wr(w)) return -1;
    case (w) 0: return wa_q_a[k]; 1: return wa_q_b[k]; default: return wa_q_c[k]; endcase
  endfunction
  function automatic int wc_at(int w, int k);
    if (k >= n_wr(w)) return -1;
    case (w) 0: return wc_q_a[k]; 1: return wc_q_b[k]; default: return wc_q_c[k]; endcase
  endfunction
  function automatic logic [31:0] wd_at(int w, int k);
    if (k >= n_wr(w)) return 32'hDEAD_BEEF;
    case (w) 0: return wd_q_a[k]; 1: return wd_q_b[k]; default: return wd_q_c[k]; endcase
  endfunction

  task automatic set_start(int w, logic v);
    case (w) 0: start_a = v; 1: start_b = v; default: start_c = v; endcase
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [79:0] mk(logic [15:0] x, logic [15:0] y, logic [15:0] m);
    return {x, y, 16'($urandom), 16'($urandom), m};
  endfunction

  function automatic logic [15:0] rnd_s(int span);
    int v;
    v = int'($urandom_range(0, 2 * span)) - span;
    return v[15:0];
  endfunction

  function automatic logic [15:0] clamp16(longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  // Direct sum of m_i*m_j*(r_j - r_i) over j != i, scaled and clamped.
  function automatic logic [31:0] ref_force(body_arr_t b, int n, int g, int i);
    longint ax, ay, mm;
    ax = 0;
    ay = 0;
    for (int j = 0; j < n; j++) begin
      if (j != i) begin
        mm = longint'({48'd0, b[i][15:0]}) * longint'({48'd0, b[j][15:0]});
        ax += mm * (longint'($signed(b[j][79:64])) - longint'($signed(b[i][79:64])));
        ay += mm * (longint'($signed(b[j][63:48])) - longint'($signed(b[i][63:48])));
      end
    end
    ax = ax >>> g;
    ay = ay >>> g;
    return {clamp16(ax), clamp16(ay)};
  endfunction

  task automatic wait_done(int w, int dn0, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (n_done(w) > dn0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic run_and_verify(int w, int n, fvec_t exp, string tag);
    int s, rd0, wr0, dn0, mism;
    int expq[$];
    bit ok;
    rd0 = n_rd(w);
    wr0 = n_wr(w);
    dn0 = n_done(w);
    set_start(w, 1'b1);
    s = cyc;
    tick();
    set_start(w, 1'b0);
    wait_done(w, dn0, ok);
    check({tag, "_done_seen"}, 64'(ok), 64'd1);
    tick();
    tick();
    check({tag, "_done_cycle"}, 64'(done_cyc(w) - s), 64'(n * (3 * n + 1) + 1));
    check({tag, "_done_pulses"}, 64'(n_done(w) - dn0), 64'd1);
    check({tag, "_writes"}, 64'(n_wr(w) - wr0), 64'(n));
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_waddr%0d", tag, k), 64'(wa_at(w, wr0 + k)), 64'(400 + k));
      check($sformatf("%s_wdata%0d", tag, k), 64'(wd_at(w, wr0 + k)), 64'(exp[k]));
      check($sformatf("%s_wcyc%0d", tag, k), 64'(wc_at(w, wr0 + k) - s), 64'((k + 1) * (3 * n + 1)));
    end
    for (int i = 0; i < n; i++) begin
      expq.push_back(i);
      for (int j = 0; j < n; j++) if (j != i) expq.push_back(j);
    end
    check({tag, "_pair_reads"}, 64'(n_rd(w) - rd0 - n), 64'(n * (n - 1)));
    mism = 0;
    foreach (expq[k]) if (rd_at(w, rd0 + k) != expq[k]) mism++;
    check({tag, "_read_order"}, 64'(mism), 64'd0);
    check({tag, "_rd_wr_overlap"}, 64'(overlaps(w)), 64'd0);
  endtask

  vec_t      tbl[7];
  body_arr_t bod;
  fvec_t     exp;
  int        s, s2, rd0, rd1, wr0, dn0;
  bit        ok;

  initial begin
    tbl[0] = '{16'h0064, 16'h0064, 16'h0005, 16'h00C8, 16'h00C8, 16'h0002, 32'h03E8_03E8, 32'hFC18_FC18};
    tbl[1] = '{16'h0000, 16'h0007, 16'h03E8, 16'h0064, 16'h0007, 16'h03E8, 32'h7FFF_0000, 32'h8000_0000};
    tbl[2] = '{16'hFFF6, 16'h0014, 16'h0003, 16'h0005, 16'hFFFC, 16'h0007, 32'h013B_FE08, 32'hFEC5_01F8};
    tbl[3] = '{16'h04D2, 16'hFFFF, 16'h0000, 16'hFFFB, 16'h0009, 16'hFFFF, 32'h0000_0000, 32'h0000_0000};
    tbl[4] = '{16'h8000, 16'h0000, 16'h0001, 16'h7FFF, 16'h0000, 16'h0001, 32'h7FFF_0000, 32'h8000_0000};
    tbl[5] = '{16'h0000, 16'h0000, 16'h0001, 16'h7FFF, 16'h0000, 16'h0001, 32'h7FFF_0000, 32'h8001_0000};
    tbl[6] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF, 32'h7FFF_8000, 32'h8000_7FFF};

    reset = 1'b1;
    repeat (3) tick();
    check("reset_outputs_n2", {busy_a, done_a, rd_a, wr_a, addr_a, faddr_a, wdata_a}, 64'd0);
    check("reset_outputs_n4", {busy_b, done_b, rd_b, wr_b, addr_b, faddr_b, wdata_b}, 64'd0);
    check("reset_outputs_n1", {busy_c, done_c, rd_c, wr_c, addr_c, faddr_c, wdata_c}, 64'd0);
    reset = 1'b0;
    tick();

    foreach (tbl[t]) begin
      mem_a[0] = mk(tbl[t].x0, tbl[t].y0, tbl[t].m0);
      mem_a[1] = mk(tbl[t].x1, tbl[t].y1, tbl[t].m1);
      exp = '{tbl[t].f0, tbl[t].f1, 32'd0, 32'd0};
      run_and_verify(0, 2, exp, $sformatf("vec%0d", t));
    end

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 2; k++) begin
        bod[k]   = mk(rnd_s(300), rnd_s(300), 16'($urandom_range(0, 40)));
        mem_a[k] = bod[k];
      end
      for (int k = 0; k < 4; k++) exp[k] = (k < 2) ? ref_force(bod, 2, 0, k) : 32'd0;
      run_and_verify(0, 2, exp, $sformatf("rand2_%0d", r));
    end

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (r == 2) bod[k] = mk(16'($urandom), 16'($urandom), 16'($urandom));
        else        bod[k] = mk(rnd_s(600), rnd_s(600), 16'($urandom_range(0, 15)));
        mem_b[k] = bod[k];
      end
      for (int k = 0; k < 4; k++) exp[k] = ref_force(bod, 4, 4, k);
      run_and_verify(1, 4, exp, $sformatf("rand4_%0d", r));
    end

    for (int r = 0; r < 2; r++) begin
      mem_c[0] = mk(16'($urandom), 16'($urandom), 16'($urandom_range(1, 65535)));
      exp = '{32'd0, 32'd0, 32'd0, 32'd0};
      run_and_verify(2, 1, exp, $sformatf("single_%0d", r));
    end

    // start held high: one sweep, one done, restart only after the idle cycle
    mem_a[0] = mk(tbl[0].x0, tbl[0].y0, tbl[0].m0);
    mem_a[1] = mk(tbl[0].x1, tbl[0].y1, tbl[0].m1);
    dn0 = n_done(0);
    wr0 = n_wr(0);
    start_a = 1'b1;
    s = cyc;
    tick();
    wait_done(0, dn0, ok);
    check("hold_done_seen", 64'(ok), 64'd1);
    check("hold_done_cycle", 64'(done_cyc(0) - s), 64'd15);
    check("hold_one_pulse", 64'(n_done(0) - dn0), 64'd1);
    tick();
    check("hold_idle_busy", 64'(busy_a), 64'd0);
    check("hold_idle_done", 64'(done_a), 64'd0);
    tick();
    check("hold_restart_busy", 64'(busy_a), 64'd1);
    start_a = 1'b0;
    s2 = s + 16;
    wait_done(0, dn0 + 1, ok);
    check("hold_second_done_seen", 64'(ok), 64'd1);
    check("hold_second_done_cycle", 64'(done_cyc(0) - s2), 64'd15);
    tick();
    tick();
    check("hold_total_pulses", 64'(n_done(0) - dn0), 64'd2);
    check("hold_total_writes", 64'(n_wr(0) - wr0), 64'd4);
    check("hold_second_f0", 64'(wd_at(0, wr0 + 2)), 64'h03E8_03E8);
    check("hold_second_f1", 64'(wd_at(0, wr0 + 3)), 64'hFC18_FC18);

    // reset in cycle 8: body 0 already written, body 1 must never be
    rd0 = n_rd(0);
    wr0 = n_wr(0);
    dn0 = n_done(0);
    start_a = 1'b1;
    s = cyc;
    tick();
    start_a = 1'b0;
    while (cyc - s < 8) tick();
    reset = 1'b1;
    tick();
    check("rst_mid_outputs", {busy_a, done_a, rd_a, wr_a, addr_a, faddr_a, wdata_a}, 64'd0);
    reset = 1'b0;
    rd1 = n_rd(0);
    repeat (20) tick();
    check("rst_mid_no_done", 64'(n_done(0) - dn0), 64'd0);
    check("rst_mid_writes", 64'(n_wr(0) - wr0), 64'd1);
    check("rst_mid_waddr", 64'(wa_at(0, wr0)), 64'd400);
    check("rst_mid_wdata", 64'(wd_at(0, wr0)), 64'h03E8_03E8);
    check("rst_mid_no_reads_after", 64'(n_rd(0) - rd1), 64'd0);
    check("rst_mid_reads_before", 64'(rd1 - rd0), 64'd3);
    check("rst_mid_idle_busy", 64'(busy_a), 64'd0);
    exp = '{32'h03E8_03E8, 32'hFC18_FC18, 32'd0, 32'd0};
    run_and_verify(0, 2, exp, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
